ad9826_serial_responder: RTL and testbench
==========================================

Name: ad9826_serial_responder

Overview:
Synthesizable model of the AD9826 3-wire serial port, acting as the responder end. It is driven by the config master (SLOAD/SCLK/SDATA) and holds an 8 x 9-bit register file. It answers read frames by driving SDATA and commits write frames. It is used for hardware loopback of the config path on boards without an ADC fitted, and as the bench model in config-master simulations. It oversamples the master's SCLK with the 100 MHz system clock.

Parameters:
REG_RESET_FLAT, 72'h0, reset value of the register file; reg n occupies bits [9n+8:9n].
SYNC_STAGES, 2, synchronizer depth applied to sload, sclk and sdata_in; legal values are 2..3.

Ports:
clk  input  1  system clock, 100 MHz
reset  input  1  synchronous, active-high
ad_sload  input  1  frame select, active low
ad_sclk  input  1  serial clock from master
sdata_in  input  1  SDATA pad input (pad buffer instantiated at top level)
sdata_out  output  1  SDATA drive value
sdata_oe  output  1  SDATA output enable
regs_flat  output  72  register file contents; reg n at [9n+8:9n]
wr_stb  output  1  one-clk pulse when a write commits
wr_addr  output  3  address of the last committed write
frame_err  output  1  one-clk pulse when a frame is aborted (see Optional Feature)

Behaviour:
- Frame format, MSB first, 16 bits: R/W (1 = read), A2..A0, 3 don't-care bits, D8..D0. Master launches bits on SCLK fall and samples on SCLK rise. SCLK only toggles while SLOAD is low.
- Input conditioning:
  - sload, sclk and sdata_in each pass through SYNC_STAGES flops, all with equal delay.
  - Sync flops reset to sload=1, sclk=0, sdata=0.
  - A rise or fall is detected by comparing the last two synchronized samples.
  - SCLK high and low phases are each at least 4 clk (the master gives 8).
- Internal state: bit counter bit_cnt, 5 bits; shift register hdr, 7 bits; data shift register, 9 bits.
- FSM states:
  - IDLE: on SLOAD fall, clear bit_cnt and go to HEADER.
  - HEADER:
    - On each SCLK rise, shift the sampled bit into hdr and increment bit_cnt.
    - When bit_cnt reaches 7, go to READ if hdr[6]=1, else go to WRITE.
  - READ:
    - On the first SCLK fall: load the shifter from reg[A], set sdata_oe=1, sdata_out=D8.
    - Each later SCLK fall shifts out the next bit.
    - Each SCLK rise increments bit_cnt.
    - At bit_cnt=16, go to DONE.
  - WRITE:
    - On each SCLK rise, shift the sampled bit into the data shifter and increment bit_cnt.
    - On the 16th rise: reg[A] <= shifter, wr_addr <= A, wr_stb=1 for the next clk, then go to DONE.
  - DONE: wait for SLOAD rise, then go to IDLE. Extra SCLK edges here are ignored.
- sdata_oe is deasserted on the first of:
  - the SCLK fall after the 16th rise;
  - detected SLOAD rise;
  - reset.
  sdata_oe is never asserted in HEADER, WRITE or IDLE.
- Abort: a SLOAD rise in HEADER, READ or WRITE before the frame completes discards the frame, leaves the register file unchanged, and returns the FSM to IDLE.
- A SLOAD fall while already in DONE or mid-frame is not possible without an intervening rise. A rise followed by a fall within the sync window is processed in order: abort first, then start a new frame.
- Don't-care bits are captured but ignored. They do not affect the address or the operation.
- Reset values:
  - regs_flat = REG_RESET_FLAT
  - sdata_out = 0, sdata_oe = 0
  - wr_stb = 0, wr_addr = 0, frame_err = 0
  - FSM = IDLE
  - If reset deasserts while SLOAD is low, the in-progress frame is ignored. A frame starts only on a detected SLOAD fall.
- Latency:
  - sdata_out changes SYNC_STAGES+1 clk after the real SCLK fall.
  - wr_stb pulses SYNC_STAGES+2 clk after the 16th real SCLK rise.
  - regs_flat updates in the same clk as wr_stb.
- Writes to the same address back-to-back are all committed, in order.

Optional Feature:
- Macro: AD9826_RESP_ERR_EN.
- Defined: frame_err pulses for one clk on every abort, including aborts during READ.
- Not defined: frame_err is tied to 0 and abort detection logic is removed. Aborted frames are still discarded.

Test Plan:
- Write frame 16'h3_1A5 format (R/W=0, A=3, D=9'h1A5) -> regs_flat[35:27]=9'h1A5, exactly one wr_stb with wr_addr=3, sdata_oe stays 0 throughout.
- After the write above, read frame for A=3 -> sdata_oe rises after the 7th SCLK rise; master samples 1,1,0,1,0,0,1,0,1; sdata_oe is 0 within SYNC_STAGES+2 clk of SLOAD rise.
- Write A=5 with don't-care bits 3'b111, D=9'h0FF -> reg 5 = 9'h0FF, reg 7 unchanged.
- SLOAD raised after 10 SCLK rises of a write to A=2 -> reg 2 unchanged, no wr_stb, one frame_err pulse (macro defined) or none (macro undefined), next full frame accepted.
- reset asserted mid-write with SLOAD low -> all regs = REG_RESET_FLAT, sdata_oe=0; the rest of that frame causes no write; next frame after SLOAD high/low writes correctly.
- Two back-to-back writes to A=0 with 1 SCLK-period gap -> two wr_stb pulses, final reg 0 equals the second value.

Source files
------------

// File: rtl/ad9826_serial_responder.sv
// ad9826_serial_responder: AD9826 3-wire serial port responder with an 8 x 9-bit register file
//   clk        100 MHz system clock; SLOAD/SCLK/SDATA are oversampled with it
//   reset      synchronous, active-high
//   ad_sload   frame select from master, active low
//   ad_sclk    serial clock from master (launch on fall, sample on rise)
//   sdata_in   SDATA pad input
//   sdata_out  SDATA drive value, valid while sdata_oe is high
//   sdata_oe   SDATA output enable, only during the data phase of a read
//   regs_flat  register file, reg n at [9n+8:9n]
//   wr_stb     one-clk pulse when a write commits (same clk as the regs_flat update)
//   wr_addr    address of the last committed write
//   frame_err  one-clk pulse on an aborted frame when AD9826_RESP_ERR_EN is defined, else 0
module ad9826_serial_responder #(
    parameter logic [71:0] REG_RESET_FLAT = 72'h0,
    parameter int          SYNC_STAGES    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ad_sload,
    input  logic        ad_sclk,
    input  logic        sdata_in,
    output logic        sdata_out,
    output logic        sdata_oe,
    output logic [71:0] regs_flat,
    output logic        wr_stb,
    output logic [2:0]  wr_addr,
    output logic        frame_err
);
    typedef enum logic [2:0] {IDLE, HEADER, READ, WRITE, DONE} state_t;
    state_t state, state_nxt;
    logic [SYNC_STAGES-1:0] sload_sy, sclk_sy, sdata_sy;
    logic                   sload_d, sclk_d;
    logic [SYNC_STAGES:0]   settle;
    logic                   armed;
    logic [4:0]             bit_cnt;
    logic [6:0]             hdr;
    logic [8:0]             shifter;
    logic                   commit;
    logic                   sload_fall, sload_rise, sclk_rise, sclk_fall, sd, in_frame;
    logic [6:0]             base;

    always_ff @(posedge clk) begin
        if (reset) begin
            sload_sy <= '1;
            sclk_sy  <= '0;
            sdata_sy <= '0;
            sload_d  <= 1'b1;
            sclk_d   <= 1'b0;
            settle   <= '0;
            armed    <= 1'b0;
        end else begin
            sload_sy <= {sload_sy[SYNC_STAGES-2:0], ad_sload};
            sclk_sy  <= {sclk_sy[SYNC_STAGES-2:0], ad_sclk};
            sdata_sy <= {sdata_sy[SYNC_STAGES-2:0], sdata_in};
            sload_d  <= sload_sy[SYNC_STAGES-1];
            sclk_d   <= sclk_sy[SYNC_STAGES-1];
            settle   <= {settle[SYNC_STAGES-1:0], 1'b1};
            // Frames start only after SLOAD has been seen high from the real pin,
            // so a frame already in flight when reset releases is ignored.
            armed    <= armed | (settle[SYNC_STAGES] & sload_sy[SYNC_STAGES-1]);
        end
    end

    assign sload_fall = armed & sload_d & ~sload_sy[SYNC_STAGES-1];
    assign sload_rise = ~sload_d & sload_sy[SYNC_STAGES-1];
    assign sclk_rise  = ~sclk_d & sclk_sy[SYNC_STAGES-1];
    assign sclk_fall  = sclk_d & ~sclk_sy[SYNC_STAGES-1];
    assign sd         = sdata_sy[SYNC_STAGES-1];
    assign in_frame   = (state == HEADER) || (state == READ) || (state == WRITE);
    assign base       = {4'b0, hdr[5:3]} * 7'd9;

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sload_fall) state_nxt = HEADER;
            HEADER:  if (bit_cnt == 5'd7) state_nxt = hdr[6] ? READ : WRITE;
            READ:    if (sclk_rise && bit_cnt == 5'd15) state_nxt = DONE;
            WRITE:   if (sclk_rise && bit_cnt == 5'd15) state_nxt = DONE;
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
        if (sload_rise) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt   <= '0;
            hdr       <= '0;
            shifter   <= '0;
            commit    <= 1'b0;
            regs_flat <= REG_RESET_FLAT;
            sdata_out <= 1'b0;
            sdata_oe  <= 1'b0;
            wr_stb    <= 1'b0;
            wr_addr   <= '0;
        end else begin
            wr_stb <= commit;
            commit <= 1'b0;
            if (commit) begin
                regs_flat[base +: 9] <= shifter;
                wr_addr              <= hdr[5:3];
            end
            if (state == IDLE && sload_fall) bit_cnt <= '0;
            if (sclk_rise && in_frame) bit_cnt <= bit_cnt + 5'd1;
            if (sclk_rise && state == HEADER) hdr <= {hdr[5:0], sd};
            if (sclk_rise && state == WRITE) shifter <= {shifter[7:0], sd};
            // A rise coinciding with SLOAD going high is an abort, not a completion.
            if (sclk_rise && state == WRITE && bit_cnt == 5'd15 && !sload_rise) commit <= 1'b1;
            if (sclk_fall && state == READ) begin
                if (bit_cnt == 5'd7) begin
                    {sdata_out, shifter} <= {regs_flat[base +: 9], 1'b0};
                    sdata_oe             <= 1'b1;
                end else begin
                    {sdata_out, shifter} <= {shifter, 1'b0};
                end
            end
            if ((sclk_fall && state == DONE) || sload_rise) sdata_oe <= 1'b0;
        end
    end

`ifdef AD9826_RESP_ERR_EN
    always_ff @(posedge clk) begin
        if (reset)
            frame_err <= 1'b0;
        else
            frame_err <= sload_rise & in_frame;
    end
`else
    assign frame_err = 1'b0;
`endif
endmodule

// File: tb/tb_ad9826_serial_responder.sv
// tb_ad9826_serial_responder: randomized self-checking bench for ad9826_serial_responder
module tb_ad9826_serial_responder;
    localparam int S = 2;
    localparam logic [71:0] RST = 72'h5A3C96E1F08D274B1E;
`ifdef AD9826_RESP_ERR_EN
    localparam int EXP_ERR = 1;
`else
    localparam int EXP_ERR = 0;
`endif

    logic        clk = 0, reset = 1, ad_sload = 1, ad_sclk = 0, sdata_in = 0;
    logic        sdata_out, sdata_oe, wr_stb, frame_err;
    logic [71:0] regs_flat;
    logic [2:0]  wr_addr;

    ad9826_serial_responder #(.REG_RESET_FLAT(RST), .SYNC_STAGES(S)) dut (
        .clk(clk), .reset(reset), .ad_sload(ad_sload), .ad_sclk(ad_sclk),
        .sdata_in(sdata_in), .sdata_out(sdata_out), .sdata_oe(sdata_oe),
        .regs_flat(regs_flat), .wr_stb(wr_stb), .wr_addr(wr_addr), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int cyc = 0;
    int stb_tot = 0, err_tot = 0, oe_tot = 0, stb_cyc = 0, oe_rise_cyc = 0;
    logic [2:0]  stb_addr = 0;
    logic [71:0] stb_regs = 0;
    logic        oe_q = 0;
    logic [8:0]  model [8];
    logic [8:0]  rd_bits;
    logic        oe_pre;
    int          rise_cyc, fall7_cyc, stb_base, err_base, oe_base;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_stb) begin
            stb_tot  = stb_tot + 1;
            stb_addr = wr_addr;
            stb_regs = regs_flat;
            stb_cyc  = cyc;
        end
        if (frame_err) err_tot = err_tot + 1;
        if (sdata_oe) oe_tot = oe_tot + 1;
        if (sdata_oe && !oe_q) oe_rise_cyc = cyc;
        oe_q = sdata_oe;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    function automatic logic [71:0] model_flat();
        logic [71:0] f;
        for (int n = 0; n < 8; n++) f[9*n +: 9] = model[n];
        return f;
    endfunction

    function automatic logic [15:0] mkw(input logic rw, input logic [2:0] a, input logic [2:0] dc, input logic [8:0] d);
        return {rw, a, dc, d};
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon();
        stb_base = stb_tot;
        err_base = err_tot;
        oe_base  = oe_tot;
    endtask

    task automatic start_frame();
        ad_sload = 0;
        wait_clk(8);
    endtask

    task automatic end_frame();
        wait_clk(8);
        ad_sload = 1;
        wait_clk(8);
    endtask

    task automatic send_bits(input logic [15:0] w, input int from, input int to);
        for (int i = from; i < to; i++) begin
            sdata_in = w[15-i];
            wait_clk(8);
            if (i >= 7) rd_bits = {rd_bits[7:0], sdata_out};
            if (i == 6) oe_pre = sdata_oe;
            ad_sclk  = 1;
            rise_cyc = cyc;
            wait_clk(8);
            ad_sclk = 0;
            if (i == 6) fall7_cyc = cyc;
        end
    endtask

    task automatic frame(input logic [15:0] w);
        clear_mon();
        start_frame();
        send_bits(w, 0, 16);
        end_frame();
    endtask

    task automatic do_write(input string nm, input logic [2:0] a, input logic [2:0] dc, input logic [8:0] d);
        frame(mkw(1'b0, a, dc, d));
        model[a] = d;
        total += 6;
        if (regs_flat !== model_flat()) begin bad++; $display("FAIL %s regs: got %h want %h", nm, regs_flat, model_flat()); end
        if (stb_tot - stb_base !== 1) begin bad++; $display("FAIL %s wr_stb count: got %0d want 1", nm, stb_tot - stb_base); end
        if (stb_addr !== a) begin bad++; $display("FAIL %s wr_addr: got %0d want %0d", nm, stb_addr, a); end
        if (stb_regs !== model_flat()) begin bad++; $display("FAIL %s regs at wr_stb: got %h want %h", nm, stb_regs, model_flat()); end
        if (stb_cyc - rise_cyc !== S + 2) begin bad++; $display("FAIL %s wr_stb latency: got %0d want %0d", nm, stb_cyc - rise_cyc, S + 2); end
        if (oe_tot - oe_base !== 0) begin bad++; $display("FAIL %s sdata_oe during write: got %0d clks want 0", nm, oe_tot - oe_base); end
    endtask

    task automatic do_read(input string nm, input logic [2:0] a, input logic [2:0] dc);
        frame(mkw(1'b1, a, dc, 9'($urandom)));
        total += 5;
        if (rd_bits !== model[a]) begin bad++; $display("FAIL %s data: got %h want %h", nm, rd_bits, model[a]); end
        if (oe_pre !== 1'b0) begin bad++; $display("FAIL %s oe before 7th rise: got %b want 0", nm, oe_pre); end
        if (oe_rise_cyc - fall7_cyc !== S + 1) begin bad++; $display("FAIL %s oe latency: got %0d want %0d", nm, oe_rise_cyc - fall7_cyc, S + 1); end
        if (stb_tot - stb_base !== 0) begin bad++; $display("FAIL %s wr_stb on read: got %0d want 0", nm, stb_tot - stb_base); end
        if (sdata_oe !== 1'b0) begin bad++; $display("FAIL %s oe after frame: got %b want 0", nm, sdata_oe); end
    endtask

    task automatic test_reset();
        reset = 1;
        wait_clk(4);
        reset = 0;
        wait_clk(10);
        for (int n = 0; n < 8; n++) model[n] = RST[9*n +: 9];
        total += 6;
        if (regs_flat !== RST) begin bad++; $display("FAIL reset regs: got %h want %h", regs_flat, RST); end
        if (sdata_oe !== 1'b0) begin bad++; $display("FAIL reset oe: got %b want 0", sdata_oe); end
        if (sdata_out !== 1'b0) begin bad++; $display("FAIL reset sdata_out: got %b want 0", sdata_out); end
        if (wr_stb !== 1'b0) begin bad++; $display("FAIL reset wr_stb: got %b want 0", wr_stb); end
        if (wr_addr !== 3'd0) begin bad++; $display("FAIL reset wr_addr: got %0d want 0", wr_addr); end
        if (frame_err !== 1'b0) begin bad++; $display("FAIL reset frame_err: got %b want 0", frame_err); end
    endtask

    task automatic test_write();
        do_write("write_a3", 3'd3, 3'($urandom), 9'h1A5);
        do_write("write_a5_dc111", 3'd5, 3'b111, 9'h0FF);
    endtask

    task automatic test_read();
        do_read("read_a3", 3'd3, 3'($urandom));
        total += 1;
        if (rd_bits !== 9'h1A5) begin bad++; $display("FAIL read_a3 literal: got %h want 1a5", rd_bits); end
        // read aborted mid-data: SLOAD rise alone must drop the driver
        clear_mon();
        start_frame();
        send_bits(mkw(1'b1, 3'd5, 3'd0, 9'd0), 0, 12);
        total += 4;
        if (sdata_oe !== 1'b1) begin bad++; $display("FAIL read_abort oe mid-read: got %b want 1", sdata_oe); end
        ad_sload = 1;
        wait_clk(S + 2);
        if (sdata_oe !== 1'b0) begin bad++; $display("FAIL read_abort oe after sload rise: got %b want 0", sdata_oe); end
        wait_clk(8);
        if (err_tot - err_base !== EXP_ERR) begin bad++; $display("FAIL read_abort frame_err: got %0d want %0d", err_tot - err_base, EXP_ERR); end
        if (regs_flat !== model_flat()) begin bad++; $display("FAIL read_abort regs: got %h want %h", regs_flat, model_flat()); end
    endtask

    task automatic test_abort();
        clear_mon();
        start_frame();
        send_bits(mkw(1'b0, 3'd2, 3'd0, 9'h155), 0, 10);
        ad_sload = 1;
        wait_clk(16);
        total += 3;
        if (regs_flat !== model_flat()) begin bad++; $display("FAIL abort regs: got %h want %h", regs_flat, model_flat()); end
        if (stb_tot - stb_base !== 0) begin bad++; $display("FAIL abort wr_stb: got %0d want 0", stb_tot - stb_base); end
        if (err_tot - err_base !== EXP_ERR) begin bad++; $display("FAIL abort frame_err: got %0d want %0d", err_tot - err_base, EXP_ERR); end
        do_write("after_abort_a2", 3'd2, 3'd0, 9'h0AA);
    endtask

    task automatic test_reset_mid();
        logic [15:0] w;
        w = mkw(1'b0, 3'd1, 3'd0, 9'h13C);
        clear_mon();
        start_frame();
        send_bits(w, 0, 8);
        reset = 1;
        wait_clk(2);
        for (int n = 0; n < 8; n++) model[n] = RST[9*n +: 9];
        total += 2;
        if (regs_flat !== RST) begin bad++; $display("FAIL reset_mid regs: got %h want %h", regs_flat, RST); end
        if (sdata_oe !== 1'b0) begin bad++; $display("FAIL reset_mid oe: got %b want 0", sdata_oe); end
        reset = 0;
        clear_mon();
        send_bits(w, 8, 16);
        end_frame();
        total += 3;
        if (stb_tot - stb_base !== 0) begin bad++; $display("FAIL reset_mid tail wr_stb: got %0d want 0", stb_tot - stb_base); end
        if (err_tot - err_base !== 0) begin bad++; $display("FAIL reset_mid tail frame_err: got %0d want 0", err_tot - err_base); end
        if (regs_flat !== model_flat()) begin bad++; $display("FAIL reset_mid tail regs: got %h want %h", regs_flat, model_flat()); end
        do_write("after_reset_a1", 3'd1, 3'd0, 9'h13C);
    endtask

    task automatic test_back_to_back();
        logic [8:0] d1, d2;
        d1 = 9'($urandom);
        d2 = ~d1;
        clear_mon();
        start_frame();
        send_bits(mkw(1'b0, 3'd0, 3'd0, d1), 0, 16);
        end_frame();
        start_frame();
        send_bits(mkw(1'b0, 3'd0, 3'd0, d2), 0, 16);
        end_frame();
        model[0] = d2;
        total += 2;
        if (stb_tot - stb_base !== 2) begin bad++; $display("FAIL b2b wr_stb count: got %0d want 2", stb_tot - stb_base); end
        if (regs_flat !== model_flat()) begin bad++; $display("FAIL b2b regs: got %h want %h", regs_flat, model_flat()); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 24; k++) begin
            if ($urandom_range(1, 0) == 1)
                do_read("rand_read", 3'($urandom), 3'($urandom));
            else
                do_write("rand_write", 3'($urandom), 3'($urandom), 9'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
